// File: rtl/pins_seq_drv.sv
// Clocked pin driver/sampler: a command FIFO feeds a two-state sequencer that applies
// {value, oe, pull-up, pull-down} states for hold+1 cycles; input pins get synchronised edge pulses.
module pins_seq_drv #(
  parameter int Width      = 1,
  parameter int Depth      = 4,
  parameter int CntW       = 8,
  parameter int SyncStages = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [Width-1:0] cmd_val_i,
  input  logic [Width-1:0] cmd_oe_i,
  input  logic [Width-1:0] cmd_pu_i,
  input  logic [Width-1:0] cmd_pd_i,
  input  logic [CntW-1:0]  cmd_hold_i,
  input  logic             flush_i,
  output logic [Width-1:0] pins_o,
  output logic [Width-1:0] pins_oe_o,
  output logic [Width-1:0] pins_pu_o,
  output logic [Width-1:0] pins_pd_o,
  output logic             busy_o,
  output logic             done_o,
  input  logic [Width-1:0] pins_i,
  output logic [Width-1:0] sample_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
);

  localparam int AW      = $clog2(Depth);
  localparam int CW      = AW + 1;
  localparam int WarmMax = SyncStages + 1;
  localparam int WW      = $clog2(WarmMax + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  typedef struct packed {
    logic [Width-1:0] val;
    logic [Width-1:0] oe;
    logic [Width-1:0] pu;
    logic [Width-1:0] pd;
    logic [CntW-1:0]  hold;
  } cmd_t;

  cmd_t             mem_q [Depth];
  cmd_t             cmd_in;
  cmd_t             head;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty, push, pop;

  logic [0:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] pins_q, pins_d;
  logic [Width-1:0] oe_q, oe_d;
  logic [Width-1:0] pu_q, pu_d;
  logic [Width-1:0] pd_q, pd_d;
  logic             done_q, done_d;

  logic [SyncStages-1:0][Width-1:0] sync_q, sync_d;
  logic [Width-1:0] prev_q, prev_d;
  logic [WW-1:0]    warm_q, warm_d;
  logic             edge_en;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  assign full        = (count_q == CW'(Depth));
  assign empty       = (count_q == '0);
  assign cmd_ready_o = ~full & ~flush_i & ~rst_i;
  assign push        = cmd_valid_i & cmd_ready_o;
  assign head        = mem_q[rd_ptr_q];

  always_comb begin
    cmd_in.val  = cmd_val_i;
    cmd_in.oe   = cmd_oe_i;
    cmd_in.pu   = cmd_pu_i;
    cmd_in.pd   = cmd_pd_i;
    cmd_in.hold = cmd_hold_i;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    pins_d  = pins_q;
    oe_d    = oe_q;
    pu_d    = pu_q;
    pd_d    = pd_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    if (flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      pins_d  = '0;
      oe_d    = '0;
      pu_d    = '0;
      pd_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!empty) pop = 1'b1;
        end
        ST_HOLD: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
          end else if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      // Pull-up beats pull-down, and both are suppressed while the pin is driven.
      if (pop) begin
        state_d = ST_HOLD;
        cnt_d   = head.hold;
        pins_d  = head.val;
        oe_d    = head.oe;
        pu_d    = head.pu & ~head.oe;
        pd_d    = head.pd & ~head.pu & ~head.oe;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Input sampler
  // ---------------------------------------------------------------------------
  always_comb begin
    sync_d[0] = pins_i;
    for (int i = 1; i < SyncStages; i++) sync_d[i] = sync_q[i-1];
    prev_d = sync_q[SyncStages-1];
    warm_d = (warm_q == WW'(WarmMax)) ? warm_q : warm_q + WW'(1);
  end

  // Edges stay masked until the chain and prev hold real pin data after reset.
  assign edge_en = (warm_q == WW'(WarmMax));

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pins_q   <= '0;
      oe_q     <= '0;
      pu_q     <= '0;
      pd_q     <= '0;
      done_q   <= 1'b0;
      sync_q   <= '0;
      prev_q   <= '0;
      warm_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pins_q   <= pins_d;
      oe_q     <= oe_d;
      pu_q     <= pu_d;
      pd_q     <= pd_d;
      done_q   <= done_d;
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      warm_q   <= warm_d;
    end
  end

  assign pins_o    = pins_q;
  assign pins_oe_o = oe_q;
  assign pins_pu_o = pu_q;
  assign pins_pd_o = pd_q;
  assign busy_o    = (state_q == ST_HOLD);
  assign done_o    = done_q;
  assign sample_o  = sync_q[SyncStages-1];
  assign rise_o    = edge_en ? (sync_q[SyncStages-1] & ~prev_q) : '0;
  assign fall_o    = edge_en ? (~sync_q[SyncStages-1] & prev_q) : '0;

endmodule
